// File: rtl/tgam_packet_parser.sv
// ThinkGear (TGAM) byte-stream parser: frames 0xAA 0xAA packets, checks the payload
// checksum and commits raw-sample / status rows only from checksum-good packets.
module tgam_packet_parser #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] raw_data,
    output logic        raw_valid,
    output logic [7:0]  poor_signal,
    output logic [7:0]  attention,
    output logic [7:0]  meditation,
    output logic        stat_valid,
    output logic        chk_err,
    output logic [15:0] pkt_count
);

    localparam logic [7:0] SYNC_BYTE = 8'hAA;
    localparam logic [7:0] EXCODE    = 8'h55;
    localparam logic [7:0] MAX_PLEN  = 8'd169;

    typedef enum logic [2:0] {SYNC1, SYNC2, PLEN, PAYLOAD, CHK} state_t;
    typedef enum logic [1:0] {ROW_CODE, ROW_VLEN, ROW_VAL} row_t;

    state_t      state, state_nxt;
    row_t        row;
    logic [7:0]  remain, sum, code, vlen, vcnt, raw_hi;
    logic [15:0] idle_cnt, shadow_raw;
    logic [7:0]  shadow_poor, shadow_att, shadow_med;
    logic        raw_pend, poor_pend, att_pend, med_pend;
    logic        commit_q, err_q;
    logic        timeout_hit, plen_ok, plen_bad, chk_good, chk_bad;

    always_ff @(posedge clk) begin
        if (rst) state <= SYNC1;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        timeout_hit = (state != SYNC1) && !rx_valid && (idle_cnt >= TIMEOUT - 16'd1);
        plen_ok     = rx_valid && (state == PLEN) && (rx_data <= MAX_PLEN);
        plen_bad    = rx_valid && (state == PLEN) && (rx_data > SYNC_BYTE);
        chk_good    = rx_valid && (state == CHK) && (rx_data == ~sum);
        chk_bad     = rx_valid && (state == CHK) && (rx_data != ~sum);
        if (timeout_hit) begin
            state_nxt = SYNC1;
        end else if (rx_valid) begin
            case (state)
                SYNC1:   if (rx_data == SYNC_BYTE) state_nxt = SYNC2;
                SYNC2:   state_nxt = (rx_data == SYNC_BYTE) ? PLEN : SYNC1;
                PLEN: begin
                    if (rx_data == SYNC_BYTE) state_nxt = PLEN;
                    else if (rx_data <= MAX_PLEN) state_nxt = (rx_data == 8'd0) ? CHK : PAYLOAD;
                    else state_nxt = SYNC1;
                end
                PAYLOAD: if (remain == 8'd1) state_nxt = CHK;
                CHK:     state_nxt = SYNC1;
                default: state_nxt = SYNC1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row         <= ROW_CODE;
            remain      <= '0;
            sum         <= '0;
            code        <= '0;
            vlen        <= '0;
            vcnt        <= '0;
            raw_hi      <= '0;
            idle_cnt    <= '0;
            shadow_raw  <= '0;
            shadow_poor <= '0;
            shadow_att  <= '0;
            shadow_med  <= '0;
            raw_pend    <= 1'b0;
            poor_pend   <= 1'b0;
            att_pend    <= 1'b0;
            med_pend    <= 1'b0;
            commit_q    <= 1'b0;
            err_q       <= 1'b0;
            raw_data    <= '0;
            raw_valid   <= 1'b0;
            poor_signal <= '0;
            attention   <= '0;
            meditation  <= '0;
            stat_valid  <= 1'b0;
            chk_err     <= 1'b0;
            pkt_count   <= '0;
        end else begin
            if (rx_valid)                 idle_cnt <= '0;
            else if (idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 16'd1;

            commit_q <= chk_good;
            err_q    <= chk_bad | plen_bad;

            if (timeout_hit) begin
                raw_pend  <= 1'b0;
                poor_pend <= 1'b0;
                att_pend  <= 1'b0;
                med_pend  <= 1'b0;
            end else if (plen_ok) begin
                remain    <= rx_data;
                sum       <= '0;
                row       <= ROW_CODE;
                raw_pend  <= 1'b0;
                poor_pend <= 1'b0;
                att_pend  <= 1'b0;
                med_pend  <= 1'b0;
            end else if (rx_valid && state == PAYLOAD) begin
                sum    <= sum + rx_data;
                remain <= remain - 8'd1;
                case (row)
                    ROW_CODE: begin
                        if (rx_data != EXCODE) begin
                            code <= rx_data;
                            if (rx_data[7]) begin
                                row <= ROW_VLEN;
                            end else begin
                                vlen <= 8'd1;
                                vcnt <= 8'd1;
                                row  <= ROW_VAL;
                            end
                        end
                    end
                    ROW_VLEN: begin
                        vlen <= rx_data;
                        vcnt <= rx_data;
                        row  <= (rx_data == 8'd0) ? ROW_CODE : ROW_VAL;
                    end
                    ROW_VAL: begin
                        vcnt <= vcnt - 8'd1;
                        if (vcnt == 8'd1) row <= ROW_CODE;
                        // High raw byte is staged so a truncated row never touches shadow_raw.
                        case (code)
                            8'h80: if (vlen == 8'd2) begin
                                if (vcnt == 8'd2) begin
                                    raw_hi <= rx_data;
                                end else begin
                                    shadow_raw <= {raw_hi, rx_data};
                                    raw_pend   <= 1'b1;
                                end
                            end
                            8'h02: begin shadow_poor <= rx_data; poor_pend <= 1'b1; end
                            8'h04: begin shadow_att  <= rx_data; att_pend  <= 1'b1; end
                            8'h05: begin shadow_med  <= rx_data; med_pend  <= 1'b1; end
                            default: ;
                        endcase
                    end
                    default: row <= ROW_CODE;
                endcase
            end

            // Shadows cannot change in the cycle after CHK (the FSM is back in SYNC1).
            raw_valid  <= commit_q & raw_pend;
            stat_valid <= commit_q & (poor_pend | att_pend | med_pend);
            chk_err    <= err_q;
            if (commit_q) begin
                pkt_count <= pkt_count + 16'd1;
                if (raw_pend)  raw_data    <= shadow_raw;
                if (poor_pend) poor_signal <= shadow_poor;
                if (att_pend)  attention   <= shadow_att;
                if (med_pend)  meditation  <= shadow_med;
            end
        end
    end

endmodule

// File: tb/tb_tgam_packet_parser.sv
// Directed bench for tgam_packet_parser: hand-computed packets, pulse counting, timeout and reset.
module tb_tgam_packet_parser;

    localparam logic [15:0] TO = 16'd20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] raw_data;
    logic        raw_valid;
    logic [7:0]  poor_signal, attention, meditation;
    logic        stat_valid, chk_err;
    logic [15:0] pkt_count;

    int n_tests = 0;
    int n_fail  = 0;
    int raw_cnt = 0;
    int stat_cnt = 0;
    int err_cnt = 0;
    logic [7:0] bq[$];

    tgam_packet_parser #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .raw_data(raw_data), .raw_valid(raw_valid), .poor_signal(poor_signal),
        .attention(attention), .meditation(meditation), .stat_valid(stat_valid),
        .chk_err(chk_err), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (raw_valid)  raw_cnt  <= raw_cnt + 1;
        if (stat_valid) stat_cnt <= stat_cnt + 1;
        if (chk_err)    err_cnt  <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_bq();
        foreach (bq[i]) send(bq[i]);
    endtask

    // Pulse cycle after the last byte, then the pulses must drop again.
    task automatic post(input string tag, input logic rv, input logic sv, input logic ce);
        step();
        chk({tag, " raw_valid"},  {31'd0, raw_valid},  {31'd0, rv});
        chk({tag, " stat_valid"}, {31'd0, stat_valid}, {31'd0, sv});
        chk({tag, " chk_err"},    {31'd0, chk_err},    {31'd0, ce});
        step();
        chk({tag, " pulses low"}, {29'd0, raw_valid, stat_valid, chk_err}, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " raw_data"}, {16'd0, raw_data}, 32'd0);
        chk({tag, " status"}, {8'd0, poor_signal, attention, meditation}, 32'd0);
        chk({tag, " pulses"}, {29'd0, raw_valid, stat_valid, chk_err}, 32'd0);
        chk({tag, " pkt_count"}, {16'd0, pkt_count}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        step();

        // Positive raw sample, with latency check on the checksum-accept cycle
        bq = '{8'hAA, 8'hAA, 8'h04, 8'h80, 8'h02, 8'h01, 8'hF4, 8'h88};
        send_bq();
        chk("p1 no early pulse", {31'd0, raw_valid}, 32'd0);
        post("p1", 1'b1, 1'b0, 1'b0);
        chk("p1 raw_data", {16'd0, raw_data}, 32'h01F4);
        chk("p1 pkt_count", {16'd0, pkt_count}, 32'd1);

        // Negative raw sample
        bq = '{8'hAA, 8'hAA, 8'h04, 8'h80, 8'h02, 8'hFF, 8'h38, 8'h46};
        send_bq();
        post("p2", 1'b1, 1'b0, 1'b0);
        chk("p2 raw_data", {16'd0, raw_data}, 32'hFF38);
        chk("p2 pkt_count", {16'd0, pkt_count}, 32'd2);

        // Bad checksum
        bq = '{8'hAA, 8'hAA, 8'h04, 8'h80, 8'h02, 8'h01, 8'hF4, 8'h89};
        send_bq();
        post("p3", 1'b0, 1'b0, 1'b1);
        chk("p3 raw_data held", {16'd0, raw_data}, 32'hFF38);
        chk("p3 pkt_count held", {16'd0, pkt_count}, 32'd2);

        // Status packet
        bq = '{8'hAA, 8'hAA, 8'h04, 8'h02, 8'hC8, 8'h04, 8'h32, 8'hFF};
        send_bq();
        post("p4", 1'b0, 1'b1, 1'b0);
        chk("p4 poor/att/med", {8'd0, poor_signal, attention, meditation}, 32'h00C83200);
        chk("p4 raw_data held", {16'd0, raw_data}, 32'hFF38);
        chk("p4 pkt_count", {16'd0, pkt_count}, 32'd3);

        // Junk and resync, including a third 0xAA in PLEN
        bq = '{8'h12, 8'hAA, 8'h55, 8'hAA, 8'hAA, 8'hAA, 8'h04, 8'h80, 8'h02, 8'h01, 8'hF4, 8'h88};
        send_bq();
        post("p5", 1'b1, 1'b0, 1'b0);
        chk("p5 raw_data", {16'd0, raw_data}, 32'h01F4);
        chk("p5 pkt_count", {16'd0, pkt_count}, 32'd4);
        chk("p5 counts", {raw_cnt[7:0], stat_cnt[7:0], err_cnt[7:0], 8'd0}, 32'h03010100);

        // PLEN too large, then a sync-less payload must be ignored
        bq = '{8'hAA, 8'hAA, 8'hB0};
        send_bq();
        post("p6", 1'b0, 1'b0, 1'b1);
        bq = '{8'h04, 8'h80, 8'h02, 8'h01, 8'hF4, 8'h88};
        send_bq();
        repeat (3) step();
        chk("p6 pkt_count held", {16'd0, pkt_count}, 32'd4);
        chk("p6 err_cnt", err_cnt, 32'd2);

        // Timeout mid-packet discards the partial packet silently
        bq = '{8'hAA, 8'hAA, 8'h04, 8'h80};
        send_bq();
        repeat (int'(TO) + 1) step();
        bq = '{8'hAA, 8'hAA, 8'h02, 8'h05, 8'h3C, 8'hBE};
        send_bq();
        post("p7", 1'b0, 1'b1, 1'b0);
        chk("p7 meditation", {24'd0, meditation}, 32'h3C);
        chk("p7 pkt_count", {16'd0, pkt_count}, 32'd5);
        chk("p7 err_cnt", err_cnt, 32'd2);

        // Gap shorter than the timeout keeps the packet alive
        bq = '{8'hAA, 8'hAA, 8'h04, 8'h80, 8'h02};
        send_bq();
        repeat (int'(TO) - 5) step();
        bq = '{8'h00, 8'h64, 8'h19};
        send_bq();
        post("p8", 1'b1, 1'b0, 1'b0);
        chk("p8 raw_data", {16'd0, raw_data}, 32'h0064);
        chk("p8 pkt_count", {16'd0, pkt_count}, 32'd6);

        // Two complete raw rows plus a truncated one: last complete wins, one pulse
        bq = '{8'hAA, 8'hAA, 8'h0B, 8'h80, 8'h02, 8'h00, 8'h10, 8'h80, 8'h02, 8'h00, 8'h20,
               8'h80, 8'h02, 8'h7F, 8'hCA};
        send_bq();
        post("p9", 1'b1, 1'b0, 1'b0);
        chk("p9 raw_data", {16'd0, raw_data}, 32'h0020);
        chk("p9 raw_cnt", raw_cnt, 32'd5);

        // Empty payload
        bq = '{8'hAA, 8'hAA, 8'h00, 8'hFF};
        send_bq();
        post("p10", 1'b0, 1'b0, 1'b0);
        chk("p10 pkt_count", {16'd0, pkt_count}, 32'd8);

        // EXCODE, attention, raw row with vlen=3 discarded
        bq = '{8'hAA, 8'hAA, 8'h08, 8'h55, 8'h04, 8'h21, 8'h80, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFC};
        send_bq();
        post("p11", 1'b0, 1'b1, 1'b0);
        chk("p11 poor/att/med", {8'd0, poor_signal, attention, meditation}, 32'h00C8213C);
        chk("p11 raw_data held", {16'd0, raw_data}, 32'h0020);
        chk("p11 pkt_count", {16'd0, pkt_count}, 32'd9);

        // Reset mid-packet
        bq = '{8'hAA, 8'hAA, 8'h04, 8'h80, 8'h02};
        send_bq();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_zero("mid reset");
        bq = '{8'hAA, 8'hAA, 8'h04, 8'h80, 8'h02, 8'h01, 8'hF4, 8'h88};
        send_bq();
        post("p12", 1'b1, 1'b0, 1'b0);
        chk("p12 raw_data", {16'd0, raw_data}, 32'h01F4);
        chk("p12 pkt_count", {16'd0, pkt_count}, 32'd1);
        chk("final counts", {raw_cnt[7:0], stat_cnt[7:0], err_cnt[7:0], 8'd0}, 32'h06030200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
